dm_bus_arbiter: RTL and testbench

- Shares one Wishbone-classic system bus between two masters:
  - the SERV CPU data port (Wishbone classic);
  - the debug module's system-bus-access master port (req/gnt/r_valid protocol).
- Fair round-robin arbitration, registered request capture, and a bus-hang timeout so a dead slave cannot wedge the CPU or the debugger.
- Sits between the CPU/debug module and the servant interconnect.

---
 rtl/dm_bus_arbiter.sv | 179 +++++++++++++++++
 tb/tb_dm_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-classic bus between the SERV data
// port and the debug module's system-bus-access port, with a bus-hang timeout.
module dm_bus_arbiter #(
  parameter int unsigned         BusWidth      = 32,
  parameter int unsigned         TimeoutCycles = 255,
  parameter logic [BusWidth-1:0] TimeoutRdata  = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // SERV data port
  input  logic [BusWidth-1:0]     cpu_adr_i,
  input  logic [BusWidth-1:0]     cpu_dat_i,
  input  logic [BusWidth/8-1:0]   cpu_sel_i,
  input  logic                    cpu_we_i,
  input  logic                    cpu_cyc_i,
  output logic [BusWidth-1:0]     cpu_rdt_o,
  output logic                    cpu_ack_o,
  // Debug module system-bus-access port
  input  logic                    dm_req_i,
  input  logic [BusWidth-1:0]     dm_add_i,
  input  logic                    dm_we_i,
  input  logic [BusWidth-1:0]     dm_wdata_i,
  input  logic [BusWidth/8-1:0]   dm_be_i,
  output logic                    dm_gnt_o,
  output logic                    dm_r_valid_o,
  output logic [BusWidth-1:0]     dm_r_rdata_o,
  // Shared system bus
  output logic [BusWidth-1:0]     wb_adr_o,
  output logic [BusWidth-1:0]     wb_dat_o,
  output logic [BusWidth/8-1:0]   wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  input  logic [BusWidth-1:0]     wb_rdt_i,
  input  logic                    wb_ack_i,
  output logic                    timeout_o
);

  localparam int unsigned SelWidth = BusWidth / 8;
  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntLast =
    CntWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_DM
  } state_e;

  state_e                r_state;
  state_e                w_state_next;

  logic [BusWidth-1:0]   r_wb_adr;
  logic [BusWidth-1:0]   r_wb_dat;
  logic [SelWidth-1:0]   r_wb_sel;
  logic                  r_wb_we;
  logic                  r_wb_cyc;
  logic                  r_cpu_ack;
  logic [BusWidth-1:0]   r_cpu_rdt;
  logic                  r_dm_rvalid;
  logic [BusWidth-1:0]   r_dm_rdata;
  logic                  r_timeout;
  logic                  r_last_dm;
  logic [CntWidth-1:0]   r_cnt;

  logic                  w_cpu_req;
  logic                  w_grant_cpu;
  logic                  w_grant_dm;
  logic                  w_timeout;
  logic                  w_done;
  logic [BusWidth-1:0]   w_resp_data;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant_cpu) begin
          w_state_next = ST_CPU;
        end else if (w_grant_dm) begin
          w_state_next = ST_DM;
        end
      end
      ST_CPU, ST_DM: begin
        if (w_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output / decision logic
  always_comb begin
    // The CPU still holds cyc in the cycle its ack is visible; that request is stale.
    w_cpu_req   = cpu_cyc_i && !r_cpu_ack;
    w_grant_cpu = (r_state == ST_IDLE) && w_cpu_req && (!dm_req_i || r_last_dm);
    w_grant_dm  = (r_state == ST_IDLE) && dm_req_i && (!w_cpu_req || !r_last_dm);
    w_timeout   = (TimeoutCycles != 0) && (r_state != ST_IDLE) && !wb_ack_i &&
                  (r_cnt == CntLast);
    w_done      = (r_state != ST_IDLE) && (wb_ack_i || w_timeout);
    w_resp_data = wb_ack_i ? wb_rdt_i : TimeoutRdata;
    // Grant is combinational; gating with reset keeps it low while reset is held.
    dm_gnt_o    = w_grant_dm && rst_ni;
  end

  // Bus request capture, response registers, round-robin memory and timeout counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wb_adr    <= '0;
      r_wb_dat    <= '0;
      r_wb_sel    <= '0;
      r_wb_we     <= 1'b0;
      r_wb_cyc    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_cpu_rdt   <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
      r_timeout   <= 1'b0;
      r_last_dm   <= 1'b1;
      r_cnt       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_cpu_ack   <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_timeout   <= 1'b0;
      if (w_grant_cpu) begin
        r_wb_adr  <= cpu_adr_i;
        r_wb_dat  <= cpu_dat_i;
        r_wb_sel  <= cpu_sel_i;
        r_wb_we   <= cpu_we_i;
        r_wb_cyc  <= 1'b1;
        r_last_dm <= 1'b0;
        r_cnt     <= '0;
      end else if (w_grant_dm) begin
        r_wb_adr  <= dm_add_i;
        r_wb_dat  <= dm_wdata_i;
        r_wb_sel  <= dm_be_i;
        r_wb_we   <= dm_we_i;
        r_wb_cyc  <= 1'b1;
        r_last_dm <= 1'b1;
        r_cnt     <= '0;
      end else if (w_done) begin
        r_wb_cyc  <= 1'b0;
        r_timeout <= w_timeout;
        if (r_state == ST_CPU) begin
          r_cpu_ack <= 1'b1;
          r_cpu_rdt <= w_resp_data;
        end else begin
          r_dm_rvalid <= 1'b1;
          r_dm_rdata  <= r_wb_we ? '0 : w_resp_data;
        end
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end
    end
  end

  assign wb_adr_o     = r_wb_adr;
  assign wb_dat_o     = r_wb_dat;
  assign wb_sel_o     = r_wb_sel;
  assign wb_we_o      = r_wb_we;
  assign wb_cyc_o     = r_wb_cyc;
  assign cpu_ack_o    = r_cpu_ack;
  assign cpu_rdt_o    = r_cpu_rdt;
  assign dm_r_valid_o = r_dm_rvalid;
  assign dm_r_rdata_o = r_dm_rdata;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: directed scenarios plus randomized
// single transfers judged against a transaction-level model of the arbiter.
module tb_dm_bus_arbiter;

  localparam int unsigned T  = 4;
  localparam logic [31:0] TO = 32'hDEAD_BEEF;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] cpu_adr_i, cpu_dat_i, cpu_rdt_o;
  logic [3:0]  cpu_sel_i;
  logic        cpu_we_i, cpu_cyc_i, cpu_ack_o;
  logic        dm_req_i, dm_we_i, dm_gnt_o, dm_r_valid_o;
  logic [31:0] dm_add_i, dm_wdata_i, dm_r_rdata_o;
  logic [3:0]  dm_be_i;
  logic [31:0] wb_adr_o, wb_dat_o, wb_rdt_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_ack_i, timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  dm_bus_arbiter #(
    .BusWidth     (32),
    .TimeoutCycles(T),
    .TimeoutRdata (TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cpu_adr_i   (cpu_adr_i),
    .cpu_dat_i   (cpu_dat_i),
    .cpu_sel_i   (cpu_sel_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_cyc_i   (cpu_cyc_i),
    .cpu_rdt_o   (cpu_rdt_o),
    .cpu_ack_o   (cpu_ack_o),
    .dm_req_i    (dm_req_i),
    .dm_add_i    (dm_add_i),
    .dm_we_i     (dm_we_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_be_i     (dm_be_i),
    .dm_gnt_o    (dm_gnt_o),
    .dm_r_valid_o(dm_r_valid_o),
    .dm_r_rdata_o(dm_r_rdata_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_sel_o    (wb_sel_o),
    .wb_we_o     (wb_we_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_rdt_i    (wb_rdt_i),
    .wb_ack_i    (wb_ack_i),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb_adr"}, wb_adr_o, 0);
    check({tag, "_wb_dat"}, wb_dat_o, 0);
    check({tag, "_wb_sel"}, {28'd0, wb_sel_o}, 0);
    check({tag, "_wb_we"}, wb_we_o, 0);
    check({tag, "_wb_cyc"}, wb_cyc_o, 0);
    check({tag, "_cpu_ack"}, cpu_ack_o, 0);
    check({tag, "_cpu_rdt"}, cpu_rdt_o, 0);
    check({tag, "_dm_gnt"}, dm_gnt_o, 0);
    check({tag, "_dm_rv"}, dm_r_valid_o, 0);
    check({tag, "_dm_rdata"}, dm_r_rdata_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
  endtask

  // One isolated transfer from IDLE. The slave acks in bus cycle 'delay'
  // (0 = first cycle wb_cyc_o is high); delay >= T means it never acks.
  task automatic xfer(input bit dm, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input bit we, input int delay,
                      input logic [31:0] rdt);
    bit          exp_to;
    logic [31:0] exp_d;
    exp_to = (delay >= int'(T));
    exp_d  = (dm && we) ? 32'h0 : (exp_to ? TO : rdt);
    if (dm) begin
      dm_req_i = 1; dm_add_i = adr; dm_wdata_i = dat; dm_be_i = sel; dm_we_i = we;
    end else begin
      cpu_cyc_i = 1; cpu_adr_i = adr; cpu_dat_i = dat; cpu_sel_i = sel; cpu_we_i = we;
    end
    #1;
    check("gnt_on_request", dm_gnt_o, dm);
    check("bus_idle_at_request", wb_cyc_o, 0);
    cycle();
    if (dm) dm_req_i = 0;
    check("bus_adr", wb_adr_o, adr);
    check("bus_dat", wb_dat_o, dat);
    check("bus_sel", {28'd0, wb_sel_o}, {28'd0, sel});
    check("bus_we", wb_we_o, we);
    for (int k = 0; k < int'(T); k++) begin
      check("bus_cyc_high", wb_cyc_o, 1);
      check("no_gnt_busy", dm_gnt_o, 0);
      check("no_resp_busy", cpu_ack_o | dm_r_valid_o | timeout_o, 0);
      if (k == delay) begin
        wb_ack_i = 1;
        wb_rdt_i = rdt;
      end
      cycle();
      wb_ack_i = 0;
      wb_rdt_i = $urandom;
      if (k == delay) break;
    end
    check("resp_bus_released", wb_cyc_o, 0);
    check("resp_cpu_ack", cpu_ack_o, !dm);
    check("resp_dm_rvalid", dm_r_valid_o, dm);
    check("resp_timeout", timeout_o, exp_to);
    if (dm) check("resp_dm_rdata", dm_r_rdata_o, exp_d);
    else    check("resp_cpu_rdt", cpu_rdt_o, exp_d);
    cpu_cyc_i = 0;
    cycle();
    check("pulse_end", cpu_ack_o | dm_r_valid_o | timeout_o, 0);
    check("idle_hold_adr", wb_adr_o, adr);
  endtask

  initial begin
    int          cpu_done, dm_done, cd, resp_m, last, rem_c, rem_d, pick;
    bit          dm_busy, prev_cyc;
    logic [31:0] resp_d;
    int          q_got[$];

    rst_ni = 0;
    cpu_adr_i = 0; cpu_dat_i = 0; cpu_sel_i = 0; cpu_we_i = 0; cpu_cyc_i = 0;
    dm_req_i = 0; dm_add_i = 0; dm_we_i = 0; dm_wdata_i = 0; dm_be_i = 0;
    wb_rdt_i = 0; wb_ack_i = 0;
    #12;
    check_all_zero("reset");
    #10 rst_ni = 1;
    cycle();

    // CPU-only read, slave acks in its third bus cycle
    xfer(0, 32'h0000_0100, 32'h0, 4'hF, 0, 2, 32'hCAFE_F00D);
    // DM write
    xfer(1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1, 1, 32'h5555_AAAA);
    // Hang: DM read never acked, then a normal CPU read
    xfer(1, 32'h0000_3000, 32'h0, 4'hF, 0, 99, 32'h0BAD_0BAD);
    xfer(0, 32'h0000_0104, 32'h0, 4'h3, 0, 0, 32'h7777_1111);
    // Ack lands exactly in the timeout cycle
    xfer(1, 32'h0000_3004, 32'h0, 4'hF, 0, int'(T) - 1, 32'h600D_DA7A);
    xfer(0, 32'h0000_0108, 32'h0, 4'hF, 0, int'(T) - 1, 32'h0123_4567);

    // Randomized isolated transfers
    for (int i = 0; i < 24; i++) begin
      bit   r_dm, r_we;
      int   r_delay;
      r_dm    = 1'($urandom_range(0, 1));
      r_we    = 1'($urandom_range(0, 1));
      r_delay = $urandom_range(0, int'(T) + 1);
      if (r_dm && r_we && r_delay >= int'(T)) r_delay = int'(T) - 1;
      xfer(r_dm, $urandom, $urandom, 4'($urandom_range(1, 15)), r_we, r_delay, $urandom);
      repeat ($urandom_range(0, 2)) cycle();
    end

    // Contention right after reset: 4 requests from each master
    rst_ni = 0; #3; rst_ni = 1;
    cycle();
    cpu_done = 0; dm_done = 0; dm_busy = 0; prev_cyc = 0; cd = 0; resp_m = -1; resp_d = 0;
    for (int n = 0; n < 300 && (cpu_done < 4 || dm_done < 4); n++) begin
      if (resp_m == 0) begin
        check("cont_cpu_ack", cpu_ack_o, 1);
        check("cont_cpu_rdt", cpu_rdt_o, resp_d);
        check("cont_gap", wb_cyc_o, 0);
        cpu_done++;
      end else if (resp_m == 1) begin
        check("cont_dm_rvalid", dm_r_valid_o, 1);
        check("cont_dm_rdata", dm_r_rdata_o, resp_d);
        check("cont_gap", wb_cyc_o, 0);
        dm_done++;
        dm_busy = 0;
      end
      resp_m   = -1;
      wb_ack_i = 0;
      if (wb_cyc_o && !prev_cyc) begin
        q_got.push_back((wb_adr_o[31:28] == 4'h2) ? 1 : 0);
        cd = $urandom_range(0, 2);
      end
      prev_cyc = wb_cyc_o;
      if (wb_cyc_o) begin
        if (cd == 0) begin
          wb_ack_i = 1;
          wb_rdt_i = $urandom;
          resp_m   = (wb_adr_o[31:28] == 4'h2) ? 1 : 0;
          resp_d   = (resp_m == 1 && wb_we_o) ? 32'h0 : wb_rdt_i;
        end else begin
          cd--;
        end
      end
      cpu_cyc_i  = (cpu_done < 4) && !cpu_ack_o;
      cpu_adr_i  = 32'h1000_0000 | 32'(cpu_done << 2);
      cpu_we_i   = 0;
      cpu_sel_i  = 4'hF;
      dm_req_i   = !dm_busy && (dm_done < 4);
      dm_add_i   = 32'h2000_0000 | 32'(dm_done << 2);
      dm_we_i    = dm_done[0];
      dm_wdata_i = $urandom;
      dm_be_i    = 4'hF;
      #1;
      if (dm_gnt_o) dm_busy = 1;
      cycle();
    end
    cpu_cyc_i = 0; dm_req_i = 0; wb_ack_i = 0;
    check("cont_all_served", (cpu_done == 4 && dm_done == 4) ? 1 : 0, 1);
    check("cont_grant_count", q_got.size(), 8);
    last = 1; rem_c = 4; rem_d = 4;
    foreach (q_got[i]) begin
      if (rem_c > 0 && rem_d > 0) pick = (last == 1) ? 0 : 1;
      else                        pick = (rem_c > 0) ? 0 : 1;
      check("cont_order", q_got[i], pick);
      last = pick;
      if (pick == 0) rem_c--; else rem_d--;
    end
    cycle();

    // Reset in the middle of a CPU transfer
    cpu_cyc_i = 1; cpu_adr_i = 32'h0000_0400; cpu_dat_i = 32'hA5A5_0001;
    cpu_sel_i = 4'hF; cpu_we_i = 1;
    cycle();
    check("rst_pre_cyc", wb_cyc_o, 1);
    dm_req_i = 1; dm_add_i = 32'h0000_5000; dm_we_i = 0; dm_be_i = 4'hF;
    #2 rst_ni = 0;
    #1;
    check_all_zero("rst_mid");
    #2 rst_ni = 1;
    #1;
    check("rst_tie_cpu_first", dm_gnt_o, 0);
    cycle();
    check("rst_cpu_granted_adr", wb_adr_o, 32'h0000_0400);
    check("rst_cpu_granted_cyc", wb_cyc_o, 1);
    check("rst_no_stale_ack", cpu_ack_o, 0);
    wb_ack_i = 1; wb_rdt_i = 32'h0;
    cycle();
    wb_ack_i = 0;
    check("rst_cpu_ack", cpu_ack_o, 1);
    cpu_cyc_i = 0;
    #1;
    check("rst_dm_next_gnt", dm_gnt_o, 1);
    cycle();
    dm_req_i = 0;
    check("rst_dm_bus_adr", wb_adr_o, 32'h0000_5000);
    wb_ack_i = 1; wb_rdt_i = 32'h4444_3333;
    cycle();
    wb_ack_i = 0;
    check("rst_dm_rvalid", dm_r_valid_o, 1);
    check("rst_dm_rdata", dm_r_rdata_o, 32'h4444_3333);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
